hazard_sequencer: RTL

Central stall/flush controller for the 5-stage pipeline. Sits beside the Decode stage. It inspects the ID instruction against the ID/EX and EX/MEM destinations and generates PCWrite, IF_IDWrite, Stall (bubble into ID/EX) and Flush (clear IF/ID). It also sequences the multi-cycle multiply/divide unit in EX through a start/busy/done handshake, holding dependent HI/LO readers in ID until the result is ready.

---
 rtl/hazard_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/flush controller and mul/div start/busy/done sequencer
module hazard_sequencer #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic        id_is_jump,
  input  logic        id_is_muldiv,
  input  logic        id_is_div,
  input  logic        id_reads_hilo,
  input  logic        idex_memread,
  input  logic        idex_regwrite,
  input  logic [4:0]  idex_wreg,
  input  logic        exmem_memread,
  input  logic [4:0]  exmem_wreg,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        Stall,
  output logic        Flush,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);

  state_t     state, state_nxt;
  logic [5:0] md_cnt, md_cnt_nxt;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, br_haz, md_haz, hz;

  // Register 0 is hardwired, so a write to it never produces a dependency.
  assign rs_ex  = id_uses_rs && (id_rs == idex_wreg)  && (idex_wreg  != 5'd0);
  assign rt_ex  = id_uses_rt && (id_rt == idex_wreg)  && (idex_wreg  != 5'd0);
  assign rs_mem = id_uses_rs && (id_rs == exmem_wreg) && (exmem_wreg != 5'd0);
  assign rt_mem = id_uses_rt && (id_rt == exmem_wreg) && (exmem_wreg != 5'd0);

  assign load_use = idex_memread && (rs_ex || rt_ex);

  // Branches compare in ID and need both operands; jr only needs rs.
  assign br_haz = (id_is_branch && ((idex_regwrite && (rs_ex || rt_ex)) ||
                                    (exmem_memread && (rs_mem || rt_mem)))) ||
                  (id_is_jump && ((idex_regwrite && rs_ex) || (exmem_memread && rs_mem)));

  assign md_haz = (id_is_muldiv || id_reads_hilo) && (state == MD_BUSY) && (md_cnt != 6'd0);

  assign hz = (load_use || br_haz || md_haz) && Reset;

  always_comb begin
    PCWrite    = !hz;
    IF_IDWrite = !hz;
    Stall      = hz;
    Flush      = Reset && !hz && ((id_is_branch && id_branch_taken) || id_is_jump);
    md_start   = Reset && !hz && id_is_muldiv;
    md_busy    = (state == MD_BUSY);
    md_done    = (state == MD_BUSY) && (md_cnt == 6'd0);
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (md_start) begin
      state_nxt  = MD_BUSY;
      md_cnt_nxt = id_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (state == MD_BUSY) begin
      if (md_cnt == 6'd0) begin
        state_nxt = RUN;
      end else begin
        md_cnt_nxt = md_cnt - 6'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= RUN;
      md_cnt       <= 6'd0;
      stall_cycles <= 16'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (Stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule
